// File: rtl/store_buffer_if.sv
// Bundle of store-push, load-lookup, memory-drain and flush signals around the store buffer.
// The slave modport is the buffer side; master is the pipeline/memory side.
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 3
);
    logic          mwmem;
    logic [AW-1:0] ma;
    logic [DW-1:0] mdi;
    logic          sb_full;
    logic          lre;
    logic [AW-1:0] la;
    logic          lhit;
    logic [DW-1:0] ldata;
    logic          load_stall;
    logic          dmem_we;
    logic [AW-1:0] dmem_a;
    logic [DW-1:0] dmem_d;
    logic          dmem_ready;
    logic          flush;
    logic          drained;
    logic [CW-1:0] count;

    modport slave (
        input  mwmem, ma, mdi, lre, la, dmem_ready, flush,
        output sb_full, lhit, ldata, load_stall, dmem_we, dmem_a, dmem_d, drained, count
    );

    modport master (
        output mwmem, ma, mdi, lre, la, dmem_ready, flush,
        input  sb_full, lhit, ldata, load_stall, dmem_we, dmem_a, dmem_d, drained, count
    );
endinterface

// File: rtl/store_buffer.sv
// Circular-FIFO store buffer draining sw stores into data memory, with load lookup and flush.
// Define SB_FORWARD_EN to build store-to-load forwarding; otherwise loads stall while stores are pending.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic           clk,
    input  logic           clrn,
    store_buffer_if.slave  sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t        state_r;
    state_t        state_s;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [AW-1:0] addr_mem_r [DEPTH];
    logic [DW-1:0] data_mem_r [DEPTH];
    logic          nonempty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;

    // Handshake decode; full is taken from the registered count only, so a pop never frees a slot early
    always_comb begin
        nonempty_s = (count_r != {CW{1'b0}});
        full_s     = (count_r == CW'(DEPTH)) || (state_r == FLUSH);
        push_s     = sb.mwmem & ~full_s;
        pop_s      = nonempty_s & sb.dmem_ready;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CW'(1);
            end
        end
    end

    // Entry storage; validity is implied by count and rd_ptr
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r] <= sb.ma;
            data_mem_r[wr_ptr_r] <= sb.mdi;
        end
    end

    // Flush FSM state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Flush FSM next state; a flush with an empty buffer still spends one cycle in FLUSH
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (sb.flush) begin
                    state_s = FLUSH;
                end else begin
                    state_s = IDLE;
                end
            end
            FLUSH: begin
                if (!nonempty_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = FLUSH;
                end
            end
            default: state_s = IDLE;
        endcase
    end

`ifdef SB_FORWARD_EN
    logic          hit_s;
    logic [DW-1:0] fwd_data_s;
    logic [PW-1:0] idx_s;

    // Walk valid entries oldest to youngest so the last match is the youngest store
    always_comb begin
        hit_s      = 1'b0;
        fwd_data_s = {DW{1'b0}};
        idx_s      = rd_ptr_r;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = rd_ptr_r + PW'(i);
            if ((CW'(i) < count_r) && (addr_mem_r[idx_s] == sb.la)) begin
                hit_s      = 1'b1;
                fwd_data_s = data_mem_r[idx_s];
            end else begin
                hit_s      = hit_s;
            end
        end
    end

    assign sb.lhit       = sb.lre & hit_s;
    assign sb.ldata      = fwd_data_s;
    assign sb.load_stall = 1'b0;
`else
    assign sb.lhit       = 1'b0;
    assign sb.ldata      = {DW{1'b0}};
    assign sb.load_stall = sb.lre & nonempty_s;
`endif

    assign sb.sb_full = full_s;
    assign sb.dmem_we = nonempty_s;
    assign sb.dmem_a  = nonempty_s ? addr_mem_r[rd_ptr_r] : {AW{1'b0}};
    assign sb.dmem_d  = nonempty_s ? data_mem_r[rd_ptr_r] : {DW{1'b0}};
    assign sb.drained = (state_r == FLUSH) && !nonempty_s;
    assign sb.count   = count_r;
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: accepted stores are queued and matched against memory writes.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = 3;

    logic clk;
    logic clrn;
    int   n_chk;
    int   n_fail;
    logic fl_m;
    logic [AW+DW-1:0] exp_q[$];

    store_buffer_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .clrn (clrn),
        .sb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle: scoreboard the state and any write handshake at the negedge, then cross the edge
    task automatic step();
        int cnt;
        logic full_m;
        logic [AW+DW-1:0] e;
        @(negedge clk);
        cnt    = exp_q.size();
        full_m = (cnt == DEPTH) || fl_m;
        n_chk++;
        if (bus.count !== CW'(cnt) || bus.sb_full !== full_m ||
            bus.dmem_we !== (cnt != 0) || bus.drained !== (fl_m && cnt == 0)) begin
            n_fail++;
            $display("FAIL status: got count=%0d full=%b we=%b drained=%b, want count=%0d full=%b we=%b drained=%b",
                     bus.count, bus.sb_full, bus.dmem_we, bus.drained,
                     cnt, full_m, (cnt != 0), (fl_m && cnt == 0));
        end
        if (cnt != 0 && bus.dmem_ready) begin
            e = exp_q.pop_front();
            n_chk++;
            if ({bus.dmem_a, bus.dmem_d} !== e) begin
                n_fail++;
                $display("FAIL write_order: got a=%h d=%h, want a=%h d=%h",
                         bus.dmem_a, bus.dmem_d, e[AW+DW-1:DW], e[DW-1:0]);
            end
        end
        if (bus.mwmem && !full_m) exp_q.push_back({bus.ma, bus.mdi});
        if (!fl_m && bus.flush) fl_m = 1'b1;
        else if (fl_m && cnt == 0) fl_m = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (bus.count !== 3'd0 || bus.sb_full !== 1'b0 || bus.lhit !== 1'b0 || bus.load_stall !== 1'b0 ||
            bus.dmem_we !== 1'b0 || bus.drained !== 1'b0 || bus.ldata !== 32'h0 ||
            bus.dmem_a !== 32'h0 || bus.dmem_d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: count=%0d full=%b lhit=%b stall=%b we=%b drained=%b ldata=%h a=%h d=%h, want all 0",
                     bus.count, bus.sb_full, bus.lhit, bus.load_stall, bus.dmem_we, bus.drained,
                     bus.ldata, bus.dmem_a, bus.dmem_d);
        end
        clrn = 1'b1;
        bus.dmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.mwmem = 1'b1;
            bus.ma    = 32'h100 + 32'(i * 4);
            bus.mdi   = 32'hA000_0000 + 32'(i);
            step();
        end
        bus.mwmem = 1'b0;
        #2;
        clrn = 1'b0;
        #1;
        n_chk++;
        if (bus.count !== 3'd0 || bus.dmem_we !== 1'b0 || bus.sb_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: count=%0d we=%b full=%b, want 0 0 0", bus.count, bus.dmem_we, bus.sb_full);
        end
        exp_q.delete();
        fl_m = 1'b0;
        @(posedge clk);
        #1;
        clrn = 1'b1;
        bus.dmem_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_single();
        bus.dmem_ready = 1'b1;
        bus.mwmem = 1'b1;
        bus.ma    = 32'h10;
        bus.mdi   = 32'hDEAD_BEEF;
        step();
        bus.mwmem = 1'b0;
        #2;
        n_chk++;
        if (bus.dmem_we !== 1'b1 || bus.dmem_a !== 32'h10 || bus.dmem_d !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_write: we=%b a=%h d=%h, want 1 00000010 deadbeef", bus.dmem_we, bus.dmem_a, bus.dmem_d);
        end
        step();
        #2;
        n_chk++;
        if (bus.count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_count: count=%0d, want 0", bus.count);
        end
    endtask

    task automatic test_full_order();
        bus.dmem_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.mwmem = 1'b1;
            bus.ma    = 32'h200 + 32'(i * 4);
            bus.mdi   = 32'hB000_0000 + 32'(i * 17);
            step();
        end
        #2;
        n_chk++;
        if (bus.sb_full !== 1'b1 || bus.count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_flag: full=%b count=%0d, want 1 4", bus.sb_full, bus.count);
        end
        bus.ma  = 32'h2F0;
        bus.mdi = 32'hBAD0_0005;
        step();
        #2;
        n_chk++;
        if (bus.count !== 3'd4) begin
            n_fail++;
            $display("FAIL fifth_refused: count=%0d, want 4", bus.count);
        end
        bus.ma  = 32'h2F4;
        bus.mdi = 32'hBAD0_0006;
        bus.dmem_ready = 1'b1;
        step();
        #2;
        n_chk++;
        if (bus.count !== 3'd3 || bus.sb_full !== 1'b0) begin
            n_fail++;
            $display("FAIL push_pop_full: count=%0d full=%b, want 3 0", bus.count, bus.sb_full);
        end
        bus.mwmem = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_forward();
        bus.dmem_ready = 1'b0;
        bus.mwmem = 1'b1;
        bus.ma    = 32'h20;
        bus.mdi   = 32'h1111_1111;
        step();
        bus.mdi   = 32'h2222_2222;
        step();
        bus.ma    = 32'h24;
        bus.mdi   = 32'h3333_3333;
        bus.lre   = 1'b1;
        bus.la    = 32'h20;
        #2;
`ifdef SB_FORWARD_EN
        n_chk++;
        if (bus.lhit !== 1'b1 || bus.ldata !== 32'h2222_2222 || bus.load_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_youngest: lhit=%b ldata=%h stall=%b, want 1 22222222 0", bus.lhit, bus.ldata, bus.load_stall);
        end
        bus.la = 32'h24;
        #1;
        n_chk++;
        if (bus.lhit !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_same_cycle_push: lhit=%b, want 0", bus.lhit);
        end
        step();
        bus.mwmem = 1'b0;
        #2;
        n_chk++;
        if (bus.lhit !== 1'b1 || bus.ldata !== 32'h3333_3333) begin
            n_fail++;
            $display("FAIL fwd_next_cycle: lhit=%b ldata=%h, want 1 33333333", bus.lhit, bus.ldata);
        end
        bus.la = 32'h28;
        #1;
        n_chk++;
        if (bus.lhit !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_miss: lhit=%b, want 0", bus.lhit);
        end
`else
        n_chk++;
        if (bus.lhit !== 1'b0 || bus.ldata !== 32'h0 || bus.load_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL nofwd_pending: lhit=%b ldata=%h stall=%b, want 0 0 1", bus.lhit, bus.ldata, bus.load_stall);
        end
        step();
        bus.mwmem = 1'b0;
`endif
        bus.la = 32'h20;
        bus.dmem_ready = 1'b1;
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) step();
        #2;
        n_chk++;
        if (bus.load_stall !== 1'b0 || bus.lhit !== 1'b0 || bus.count !== 3'd0) begin
            n_fail++;
            $display("FAIL load_after_drain: stall=%b lhit=%b count=%0d, want 0 0 0", bus.load_stall, bus.lhit, bus.count);
        end
        bus.lre = 1'b0;
    endtask

    task automatic test_flush();
        int seen;
        bus.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mwmem = 1'b1;
            bus.ma    = 32'h300 + 32'(i * 4);
            bus.mdi   = 32'hC000_0000 + 32'(i);
            step();
        end
        bus.mwmem = 1'b0;
        bus.dmem_ready = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.mwmem = 1'b1;
        bus.ma    = 32'h3F0;
        bus.mdi   = 32'hBAD0_00FF;
        #2;
        n_chk++;
        if (bus.sb_full !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_blocks_push: full=%b, want 1", bus.sb_full);
        end
        seen = -1;
        for (int k = 0; k < 8; k++) begin
            if (bus.drained === 1'b1) begin
                seen = k;
                break;
            end
            step();
            #2;
        end
        bus.mwmem = 1'b0;
        n_chk++;
        if (seen != 2) begin
            n_fail++;
            $display("FAIL flush_drained_cycle: drained at cycle %0d, want 2 (-1 means timeout)", seen);
        end
        step();
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        #2;
        n_chk++;
        if (bus.drained !== 1'b1 || bus.sb_full !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_empty: drained=%b full=%b, want 1 1", bus.drained, bus.sb_full);
        end
        step();
        #2;
        n_chk++;
        if (bus.drained !== 1'b0 || bus.sb_full !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty_exit: drained=%b full=%b, want 0 0", bus.drained, bus.sb_full);
        end
    endtask

    task automatic test_back_to_back();
        bus.dmem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.mwmem = 1'b1;
            bus.ma    = 32'h40 + 32'((i % 2) * 4);
            bus.mdi   = 32'($urandom);
            step();
            #2;
            n_chk++;
            if (bus.count !== 3'd1) begin
                n_fail++;
                $display("FAIL b2b_count: iter %0d count=%0d, want 1", i, bus.count);
            end
        end
        bus.mwmem = 1'b0;
        step();
        step();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        fl_m = 1'b0;
        clrn = 1'b0;
        bus.mwmem = 1'b0;
        bus.ma = 32'h0;
        bus.mdi = 32'h0;
        bus.lre = 1'b0;
        bus.la = 32'h0;
        bus.dmem_ready = 1'b0;
        bus.flush = 1'b0;
        test_reset();
        test_single();
        test_full_order();
        test_forward();
        test_flush();
        test_back_to_back();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d stores never written, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Write-side companion to the data memory read path in the five-stage pipeline: it accepts `sw` stores leaving the EXE/MEM register, queues them in a small circular FIFO, and drains them one word per handshake into the data memory write port. Loads in the MEM stage look up the buffer so they return the youngest pending store to the same address. When the buffer is full, the front end is stalled.

## Interface
- `DEPTH`, 4: number of store entries; a power of two, at least 2.
- `AW`, 32: address width in bits; addresses are byte addresses of aligned words.
- `DW`, 32: data width in bits.

- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `clrn` in 1: asynchronous, active-low reset.
- `mwmem` in 1: store request from the EXE/MEM register.
- `ma` in AW: store address (the ALU result `mr`).
- `mdi` in DW: store data (the register `qb` value).
- `sb_full` out 1: buffer holds DEPTH entries; the pipeline must hold the MEM-stage store.
- `lre` in 1: a MEM-stage load is active.
- `la` in AW: load address.
- `lhit` out 1: a pending store matches `la`.
- `ldata` out DW: data of the youngest matching entry.
- `load_stall` out 1: the load must wait.
- `dmem_we` out 1: head entry is valid and offered to memory.
- `dmem_a` out AW: head entry address.
- `dmem_d` out DW: head entry data.
- `dmem_ready` in 1: memory accepts the offered write this cycle.
- `flush` in 1: request to drain all entries.
- `drained` out 1: a one-cycle pulse when a flush completes.
- `count` out log2(DEPTH)+1: number of occupied entries.

## Operation
- Storage is a circular FIFO with pointers `wr_ptr` and `rd_ptr` (log2(DEPTH) bits, wrapping modulo DEPTH) and an occupancy counter `count`.
- **Push:** on a rising edge with `mwmem=1` and `sb_full=0`, write {`ma`,`mdi`} at `wr_ptr`, then increment `wr_ptr`. If `sb_full=1`, the store is not accepted. The pipeline holds the store and re-presents it.
- **Pop:** `dmem_we = (count!=0)`. On a rising edge with `dmem_we=1` and `dmem_ready=1`, increment `rd_ptr`.
- **Simultaneous push and pop:** both happen and `count` is unchanged. A push into a full buffer is refused even if a pop occurs in the same cycle, because `sb_full` is decoded from `count` alone.
- **Lookup:** combinational. Compare the full `la` against every valid entry. `lhit=lre & any match`. `ldata` comes from the match closest to `wr_ptr` (the youngest). A store being pushed in the same cycle is not searched.
- **Load stall:** `load_stall=0`, except as described under Configuration.
- **Flush FSM, states IDLE and FLUSH:**
  - IDLE to FLUSH when `flush=1`.
  - While in FLUSH, `sb_full` is forced to 1, so no pushes are accepted.
  - FLUSH to IDLE on the first edge where `count==0`. `drained` pulses high during that cycle.
  - `flush` asserted with `count==0` still passes through FLUSH for one cycle, so `drained` goes high the cycle after `flush`.
  - `flush` is ignored while already in FLUSH.
- **Write-write ordering:** entries drain strictly in FIFO order. Two stores to the same address are both written, oldest first.

## Timing
- **Reset values:** `count=0`, both pointers 0, FSM in IDLE, all entries invalid. Outputs `sb_full`, `lhit`, `load_stall`, `dmem_we` and `drained` are 0. Outputs `ldata`, `dmem_a` and `dmem_d` are 0.
- Reset asserted mid-drain discards all pending stores. No write is offered while `clrn=0`.
- **Latency:** a store accepted at edge N appears on `dmem_*` in cycle N+1 if the buffer was empty. It is forwardable to loads from cycle N+1.
- `dmem_we`, `dmem_a` and `dmem_d` are held stable until the edge at which `dmem_ready=1` is sampled.
- `sb_full` and `count` change only at rising edges. `lhit`, `ldata` and `load_stall` are combinational from `la`, `lre` and the stored state.

## Configuration
- `SB_FORWARD_EN` defined: the lookup compare logic is built as described.
- `SB_FORWARD_EN` not defined:
  - No compare logic is built; `lhit=0` and `ldata=0`.
  - `load_stall = lre & (count!=0)`, so every load waits until the buffer is empty.

## Test plan
- **Reset mid-activity:** push 2 stores, assert `clrn=0` -> `count=0`, `dmem_we=0`, `sb_full=0` immediately. After release, no write is ever issued.
- **Single store, single write:** push {0x10, 0xDEADBEEF} with `dmem_ready=1` -> next cycle `dmem_we=1`, `dmem_a=0x10`, `dmem_d=0xDEADBEEF`. After that edge, `count=0`.
- **Full buffer and FIFO order:**
  - Hold `dmem_ready=0` and push 4 stores -> `sb_full=1` and `count=4`.
  - A 5th push is refused.
  - Release `dmem_ready` -> writes appear in push order; `sb_full` drops after the first pop.
- **Youngest match forwarded:** push {0x20, 0x11111111}, then {0x20, 0x22222222}, with `dmem_ready=0`. Apply `lre=1`, `la=0x20` -> `lhit=1`, `ldata=0x22222222`. With `la=0x24` -> `lhit=0`.
- **Flush:** with 3 entries and `dmem_ready=1`, pulse `flush` -> pushes are refused. `drained` pulses in the cycle `count` reaches 0. With an empty buffer, `drained` goes high one cycle after `flush`.
- **Forwarding compiled out:** without `SB_FORWARD_EN`, with 1 entry pending and `lre=1` -> `load_stall=1` and `lhit=0`. Once drained, `load_stall=0`.
